// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcodes, control-word bit positions,
// T-state count and the control word type.
package cpu_pkg;

   localparam int NUM_STEPS = 5;
   localparam int CW_W      = 16;

   typedef logic [CW_W-1:0] ctrl_t;

   // Control word bit positions, MSB first.
   localparam int HLT = 15;
   localparam int MI  = 14;
   localparam int RI  = 13;
   localparam int RO  = 12;
   localparam int IO  = 11;
   localparam int II  = 10;
   localparam int AI  = 9;
   localparam int AO  = 8;
   localparam int EO  = 7;
   localparam int SU  = 6;
   localparam int BI  = 5;
   localparam int OI  = 4;
   localparam int CE  = 3;
   localparam int CO  = 2;
   localparam int J   = 1;
   localparam int FI  = 0;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   function automatic ctrl_t cw_bit(input int idx);
      return ctrl_t'(1) << idx;
   endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode table: (opcode, T-state, flags) -> control word.
// Steps 0 and 1 are the shared fetch; unlisted opcode/step pairs emit nothing.
module microcode_rom
   import cpu_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic [2:0] step,
   input  logic       cf,
   input  logic       zf,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (step)
         3'd0: ctrl = cw_bit(CO) | cw_bit(MI);
         3'd1: ctrl = cw_bit(RO) | cw_bit(II) | cw_bit(CE);
         3'd2: begin
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl = cw_bit(IO) | cw_bit(MI);
               OP_LDI: ctrl = cw_bit(IO) | cw_bit(AI);
               OP_JMP: ctrl = cw_bit(IO) | cw_bit(J);
               // Flags are stable here: the ALU only updates them on fi.
               OP_JC:  if (cf) ctrl = cw_bit(IO) | cw_bit(J);
               OP_JZ:  if (zf) ctrl = cw_bit(IO) | cw_bit(J);
               OP_OUT: ctrl = cw_bit(AO) | cw_bit(OI);
               OP_HLT: ctrl = cw_bit(HLT);
               default: ctrl = '0;
            endcase
         end
         3'd3: begin
            case (opcode)
               OP_LDA:         ctrl = cw_bit(RO) | cw_bit(AI);
               OP_ADD, OP_SUB: ctrl = cw_bit(RO) | cw_bit(BI);
               OP_STA:         ctrl = cw_bit(AO) | cw_bit(RI);
               default:        ctrl = '0;
            endcase
         end
         3'd4: begin
            case (opcode)
               OP_ADD:  ctrl = cw_bit(EO) | cw_bit(AI) | cw_bit(FI);
               OP_SUB:  ctrl = cw_bit(EO) | cw_bit(AI) | cw_bit(SU) | cw_bit(FI);
               default: ctrl = '0;
            endcase
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Microcode sequencer: T-state counter, halt latch and output gating around
// the microcode ROM. Every instruction occupies all NUM_STEPS states.
module control_unit #(
   parameter int NUM_STEPS = cpu_pkg::NUM_STEPS,
   parameter int CW_W      = cpu_pkg::CW_W
) (
   input  logic            clk,
   input  logic            clr_n,
   input  logic [3:0]      opcode,
   input  logic            cf,
   input  logic            zf,
   output logic [CW_W-1:0] ctrl,
   output logic [2:0]      step,
   output logic            halted
);

   import cpu_pkg::ctrl_t;
   import cpu_pkg::HLT;
   import cpu_pkg::cw_bit;

   localparam logic [2:0] STEP_LAST = 3'(NUM_STEPS - 1);

   logic [2:0] r_step;
   logic       r_halted;
   ctrl_t      w_rom_ctrl;

   microcode_rom u_rom (
      .opcode (opcode),
      .step   (r_step),
      .cf     (cf),
      .zf     (zf),
      .ctrl   (w_rom_ctrl)
   );

   // Leaving HLT step 2 the counter lands on 3 and stays there until reset.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         r_step   <= 3'd0;
         r_halted <= 1'b0;
      end else if (!r_halted) begin
         if (r_step == 3'd2 && w_rom_ctrl[HLT]) begin
            r_halted <= 1'b1;
         end
         if (r_step == STEP_LAST) begin
            r_step <= 3'd0;
         end else begin
            r_step <= r_step + 3'd1;
         end
      end
   end

   always_comb begin
      ctrl = '0;
      if (!clr_n) begin
         ctrl = '0;
      end else if (r_halted) begin
         ctrl = cw_bit(HLT);
      end else begin
         ctrl = w_rom_ctrl;
      end
   end

   assign step   = r_step;
   assign halted = r_halted;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each opcode through its five T-states
// and checks control words, halt behaviour and mid-instruction reset.
module tb_control_unit;

   logic        clk = 1'b0;
   logic        clr_n = 1'b0;
   logic [3:0]  opcode = 4'h0;
   logic        cf = 1'b0;
   logic        zf = 1'b0;
   logic [15:0] ctrl;
   logic [2:0]  step;
   logic        halted;

   int checks = 0;
   int errors = 0;

   localparam logic [15:0] B_HLT = 16'h8000;
   localparam logic [15:0] B_MI  = 16'h4000;
   localparam logic [15:0] B_RI  = 16'h2000;
   localparam logic [15:0] B_RO  = 16'h1000;
   localparam logic [15:0] B_IO  = 16'h0800;
   localparam logic [15:0] B_II  = 16'h0400;
   localparam logic [15:0] B_AI  = 16'h0200;
   localparam logic [15:0] B_AO  = 16'h0100;
   localparam logic [15:0] B_EO  = 16'h0080;
   localparam logic [15:0] B_SU  = 16'h0040;
   localparam logic [15:0] B_BI  = 16'h0020;
   localparam logic [15:0] B_OI  = 16'h0010;
   localparam logic [15:0] B_CE  = 16'h0008;
   localparam logic [15:0] B_CO  = 16'h0004;
   localparam logic [15:0] B_J   = 16'h0002;
   localparam logic [15:0] B_FI  = 16'h0001;

   always #5 clk = ~clk;

   control_unit dut (
      .clk    (clk),
      .clr_n  (clr_n),
      .opcode (opcode),
      .cf     (cf),
      .zf     (zf),
      .ctrl   (ctrl),
      .step   (step),
      .halted (halted)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge: check one T-state, then move to the next falling edge.
   task automatic cyc(input string tag, input logic [2:0] s, input logic [15:0] c, input logic h);
      #1;
      check($sformatf("%s s%0d step", tag, s), 32'(step), 32'(s));
      check($sformatf("%s s%0d ctrl", tag, s), 32'(ctrl), 32'(c));
      check($sformatf("%s s%0d halted", tag, s), 32'(halted), 32'(h));
      @(negedge clk);
   endtask

   task automatic run_instr(input string tag, input logic [3:0] op, input logic c, input logic z,
                            input logic [15:0] e2, input logic [15:0] e3, input logic [15:0] e4);
      opcode = op;
      cf     = c;
      zf     = z;
      cyc(tag, 3'd0, B_CO | B_MI, 1'b0);
      cyc(tag, 3'd1, B_RO | B_II | B_CE, 1'b0);
      cyc(tag, 3'd2, e2, 1'b0);
      cyc(tag, 3'd3, e3, 1'b0);
      cyc(tag, 3'd4, e4, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      clr_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("reset ctrl", 32'(ctrl), 32'h0);
      check("reset step", 32'(step), 32'h0);
      check("reset halted", 32'(halted), 32'h0);

      clr_n = 1'b1;
      run_instr("LDI", 4'h5, 1'b0, 1'b0, B_IO | B_AI, 16'h0, 16'h0);
      run_instr("LDA", 4'h1, 1'b0, 1'b0, B_IO | B_MI, B_RO | B_AI, 16'h0);
      run_instr("ADD", 4'h2, 1'b0, 1'b0, B_IO | B_MI, B_RO | B_BI, B_EO | B_AI | B_FI);
      run_instr("SUB", 4'h3, 1'b0, 1'b0, B_IO | B_MI, B_RO | B_BI, B_EO | B_AI | B_SU | B_FI);
      run_instr("STA", 4'h4, 1'b0, 1'b0, B_IO | B_MI, B_AO | B_RI, 16'h0);
      run_instr("JMP", 4'h6, 1'b0, 1'b0, B_IO | B_J, 16'h0, 16'h0);
      run_instr("JC1", 4'h7, 1'b1, 1'b0, B_IO | B_J, 16'h0, 16'h0);
      run_instr("JC0", 4'h7, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0);
      run_instr("JZ1", 4'h8, 1'b0, 1'b1, B_IO | B_J, 16'h0, 16'h0);
      run_instr("JZ0", 4'h8, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
      run_instr("NOP", 4'h0, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0);
      run_instr("OUT", 4'hE, 1'b0, 1'b0, B_AO | B_OI, 16'h0, 16'h0);
      for (int op = 9; op <= 13; op++) begin
         run_instr($sformatf("OP%0h", op), 4'(op), 1'b1, 1'b1, 16'h0, 16'h0, 16'h0);
      end

      // Reset during ADD step 3: no fi may ever appear.
      opcode = 4'h2;
      cf     = 1'b0;
      zf     = 1'b0;
      cyc("ADDRST", 3'd0, B_CO | B_MI, 1'b0);
      cyc("ADDRST", 3'd1, B_RO | B_II | B_CE, 1'b0);
      cyc("ADDRST", 3'd2, B_IO | B_MI, 1'b0);
      #1;
      check("ADDRST s3 ctrl", 32'(ctrl), 32'(B_RO | B_BI));
      clr_n = 1'b0;
      #1;
      check("ADDRST ctrl while low", 32'(ctrl), 32'h0);
      @(negedge clk);
      check("ADDRST step after reset", 32'(step), 32'h0);
      check("ADDRST ctrl after edge low", 32'(ctrl), 32'h0);
      clr_n = 1'b1;
      run_instr("ADDREC", 4'h2, 1'b0, 1'b0, B_IO | B_MI, B_RO | B_BI, B_EO | B_AI | B_FI);

      // Halt: latches on leaving step 2 and freezes at step 3.
      opcode = 4'hF;
      cyc("HLT", 3'd0, B_CO | B_MI, 1'b0);
      cyc("HLT", 3'd1, B_RO | B_II | B_CE, 1'b0);
      cyc("HLT", 3'd2, B_HLT, 1'b0);
      opcode = 4'h2;
      for (int i = 0; i < 11; i++) begin
         cyc("HALTED", 3'd3, B_HLT, 1'b1);
      end
      clr_n = 1'b0;
      #1;
      check("HLTRST ctrl while low", 32'(ctrl), 32'h0);
      @(negedge clk);
      check("HLTRST step", 32'(step), 32'h0);
      check("HLTRST halted", 32'(halted), 32'h0);
      check("HLTRST ctrl", 32'(ctrl), 32'h0);
      clr_n = 1'b1;
      run_instr("LDI2", 4'h5, 1'b0, 1'b0, B_IO | B_AI, 16'h0, 16'h0);
      cyc("WRAP", 3'd0, B_CO | B_MI, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
